// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receiver and transmitter.
//   rx_state_t  - receiver FSM states
//   IDLE_LEVEL  - line level when no frame is in flight (mark)
//   par_calc    - parity bit a transmitter would send for a data word
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Words narrower than 8 bits are zero-extended by the caller.
  // Zero bits do not change the XOR.
  function automatic logic par_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for one asynchronous input.
// Both flops load RESET_VAL while rst is high.
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   i_async  in   asynchronous input
//   o_sync   out  input after two flops (2 cycles of latency)
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver for 8N1 frames, with an optional parity bit.
// Each bit is taken as the 3-sample majority around mid-bit.
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   rx          in   asynchronous serial line, idle high
//   rx_data     out  last good word; held until the next good word
//   rx_valid    out  1-cycle pulse when rx_data has just been updated
//   frame_err   out  1-cycle pulse when the stop bit is read as 0
//   parity_err  out  1-cycle pulse together with rx_valid on a parity mismatch
//   busy        out  high whenever the FSM is not idle
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_M_M1 = CW'(M - 1);
  localparam logic [CW-1:0] CNT_M    = CW'(M);
  localparam logic [CW-1:0] CNT_M_P1 = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_t            r_state,     w_state_next;
  logic [CW-1:0]        r_bit_cnt,   w_bit_cnt_next;
  logic [IW-1:0]        r_bit_idx,   w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift,     w_shift_next;
  logic                 r_par_err,   w_par_err_next;
  logic [DATA_BITS-1:0] r_rx_data,   w_rx_data_next;
  logic                 r_rx_valid,  w_rx_valid_next;
  logic                 r_frame_err, w_frame_err_next;
  logic                 r_parity_err, w_parity_err_next;
  logic                 r_s_early;  // rx_s at count M-1
  logic                 r_s_mid;    // rx_s at count M

  logic w_maj;
  logic w_resolve;
  logic w_bit_end;

  uart_sync2 #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  // The third sample is the live rx_s at count M+1.
  // The bit is resolved in that same cycle.
  assign w_maj     = (r_s_early & r_s_mid) | (r_s_early & w_rx_s) | (r_s_mid & w_rx_s);
  assign w_resolve = (r_bit_cnt == CNT_M_P1);
  assign w_bit_end = (r_bit_cnt == CNT_LAST);

  always_comb begin
    w_state_next      = r_state;
    w_bit_cnt_next    = r_bit_cnt + 1'b1;
    w_bit_idx_next    = r_bit_idx;
    w_shift_next      = r_shift;
    w_par_err_next    = r_par_err;
    w_rx_data_next    = r_rx_data;
    w_rx_valid_next   = 1'b0;
    w_frame_err_next  = 1'b0;
    w_parity_err_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_bit_cnt_next = '0;
        w_bit_idx_next = '0;
        if (w_rx_s != IDLE_LEVEL) begin
          w_state_next   = START;
          w_par_err_next = 1'b0;
        end
      end
      START: begin
        if (w_resolve && w_maj) begin
          // The start bit did not hold low through mid-bit, so treat it as a glitch.
          w_state_next   = IDLE;
          w_bit_cnt_next = '0;
        end else if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
        end
      end
      DATA: begin
        // Shift in from the top so the first (LSB) bit ends up in bit 0.
        if (w_resolve) begin
          w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
        end
        if (w_bit_end) begin
          w_bit_cnt_next = '0;
          if (r_bit_idx == IDX_LAST) begin
            w_bit_idx_next = '0;
            w_state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_resolve) begin
          w_par_err_next = (w_maj != par_calc(8'(r_shift), 1'(PARITY_ODD)));
        end
        if (w_bit_end) begin
          w_state_next   = STOP;
          w_bit_cnt_next = '0;
        end
      end
      STOP: begin
        // Leave at mid stop bit.
        // This re-arms IDLE before a back-to-back start edge can arrive.
        if (w_resolve) begin
          w_bit_cnt_next = '0;
          if (w_maj) begin
            w_rx_data_next    = r_shift;
            w_rx_valid_next   = 1'b1;
            w_parity_err_next = r_par_err;
            w_state_next      = IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so that it reports only one frame_err.
        w_bit_cnt_next = '0;
        if (w_rx_s == IDLE_LEVEL) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_bit_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_s_early    <= IDLE_LEVEL;
      r_s_mid      <= IDLE_LEVEL;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
      r_par_err    <= w_par_err_next;
      r_rx_data    <= w_rx_data_next;
      r_rx_valid   <= w_rx_valid_next;
      r_frame_err  <= w_frame_err_next;
      r_parity_err <= w_parity_err_next;
      if (r_bit_cnt == CNT_M_M1) r_s_early <= w_rx_s;
      if (r_bit_cnt == CNT_M)    r_s_mid   <= w_rx_s;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = (r_state != IDLE);

endmodule
